// File: rtl/counting_register_pkg.sv
// rtl/counting_register_pkg.sv - shared op encodings and sizing helper for counting_register
package counting_register_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_HOLD  = 3'd0;
  localparam logic [OP_W-1:0] OP_CLEAR = 3'd1;
  localparam logic [OP_W-1:0] OP_WRITE = 3'd2;
  localparam logic [OP_W-1:0] OP_POP   = 3'd3;
  localparam logic [OP_W-1:0] OP_INC   = 3'd4;
  localparam logic [OP_W-1:0] OP_DEC   = 3'd5;

  // Never returns less than 1 so a one-entry stack still gets a real index bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/counting_register_if.sv
// rtl/counting_register_if.sv - control/status bundle between the datapath and counting_register
interface counting_register_if #(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 4
);
  logic              clear;
  logic              write;
  logic [WIDTH-1:0]  datain;
  logic              inc;
  logic              dec;
  logic [STEP_W-1:0] step;
  logic              push;
  logic              pop;
  logic              flag_clr;
  logic [WIDTH-1:0]  dataout;
  logic              zero;
  logic              carry;
  logic              stk_full;
  logic              stk_empty;
  logic              stk_err;

  modport master (
    output clear, write, datain, inc, dec, step, push, pop, flag_clr,
    input  dataout, zero, carry, stk_full, stk_empty, stk_err
  );

  modport slave (
    input  clear, write, datain, inc, dec, step, push, pop, flag_clr,
    output dataout, zero, carry, stk_full, stk_empty, stk_err
  );
endinterface

// File: rtl/counting_register_lifo_stack.sv
// rtl/counting_register_lifo_stack.sv - save/restore LIFO with pointer, full/empty and accept strobes
module lifo_stack
  import counting_register_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_push_ok,
  output logic             o_pop_ok
);
  localparam int PTR_W = clog2(DEPTH + 1);
  localparam int IDX_W = clog2(DEPTH);

  logic [PTR_W-1:0] r_ptr;
  logic [WIDTH-1:0] r_mem [2**IDX_W];
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_top_idx;

  assign o_full    = (r_ptr == PTR_W'(DEPTH));
  assign o_empty   = (r_ptr == '0);
  assign o_push_ok = i_push & ~o_full;
  assign o_pop_ok  = i_pop & ~o_empty;

  assign w_wr_idx  = IDX_W'(r_ptr);
  assign w_top_idx = IDX_W'(r_ptr - PTR_W'(1));
  assign o_top     = r_mem[w_top_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (o_push_ok) begin
      r_ptr <= r_ptr + PTR_W'(1);
    end else if (o_pop_ok) begin
      r_ptr <= r_ptr - PTR_W'(1);
    end
  end

  // Entries are meaningless once the pointer is reset, so storage skips the reset.
  always_ff @(posedge clk) begin
    if (o_push_ok) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end
endmodule

// File: rtl/counting_register.sv
// rtl/counting_register.sv - PC/AR/loop-counter register with step arithmetic, sticky flags and call stack
module counting_register
  import counting_register_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter int               STEP_W      = 4,
  parameter int               SATURATE    = 0,
  parameter int               STACK_DEPTH = 4
) (
  input logic                clk,
  input logic                rst_n,
  counting_register_if.slave bus
);
  logic [WIDTH-1:0] r_data;
  logic             r_carry;
  logic             r_stk_err;

  logic             w_push_req;
  logic             w_pop_req;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic             w_full;
  logic             w_empty;
  logic [WIDTH-1:0] w_top;
  logic [OP_W-1:0]  w_op;
  logic [WIDTH:0]   w_amount;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_next;
  logic             w_carry_evt;
  logic             w_err_evt;

  // push+pop cancel each other; a pop shadowed by clear/write is simply dropped.
  assign w_push_req = bus.push & ~bus.pop;
  assign w_pop_req  = bus.pop & ~bus.push & ~bus.clear & ~bus.write;

  lifo_stack #(
    .WIDTH (WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push_req),
    .i_pop     (w_pop_req),
    .i_data    (r_data),
    .o_top     (w_top),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_push_ok (w_push_ok),
    .o_pop_ok  (w_pop_ok)
  );

  assign w_amount = (WIDTH + 1)'(bus.step) + (WIDTH + 1)'(1);
  assign w_sum    = {1'b0, r_data} + w_amount;
  assign w_diff   = {1'b0, r_data} - w_amount;

  always_comb begin
    w_op = OP_HOLD;
    if (bus.clear)                 w_op = OP_CLEAR;
    else if (bus.write)            w_op = OP_WRITE;
    else if (w_pop_ok)             w_op = OP_POP;
    else if (bus.inc && !bus.dec)  w_op = OP_INC;
    else if (bus.dec && !bus.inc)  w_op = OP_DEC;
  end

  // Bit WIDTH of the extended sum/difference is the wrap (carry or borrow) indicator.
  always_comb begin
    w_next      = r_data;
    w_carry_evt = 1'b0;
    case (w_op)
      OP_CLEAR: w_next = RESET_VAL;
      OP_WRITE: w_next = bus.datain;
      OP_POP:   w_next = w_top;
      OP_INC: begin
        w_carry_evt = w_sum[WIDTH];
        w_next      = (w_sum[WIDTH] && SATURATE != 0) ? '1 : w_sum[WIDTH-1:0];
      end
      OP_DEC: begin
        w_carry_evt = w_diff[WIDTH];
        w_next      = (w_diff[WIDTH] && SATURATE != 0) ? '0 : w_diff[WIDTH-1:0];
      end
      default: ;
    endcase
  end

  assign w_err_evt = (bus.push & bus.pop)
                   | (w_push_req & ~w_push_ok)
                   | (w_pop_req & ~w_pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data    <= RESET_VAL;
      r_carry   <= 1'b0;
      r_stk_err <= 1'b0;
    end else begin
      r_data <= w_next;
      if (w_carry_evt)       r_carry <= 1'b1;
      else if (bus.flag_clr) r_carry <= 1'b0;
      if (w_err_evt)         r_stk_err <= 1'b1;
      else if (bus.flag_clr) r_stk_err <= 1'b0;
    end
  end

  assign bus.dataout   = r_data;
  assign bus.zero      = (r_data == '0);
  assign bus.carry     = r_carry;
  assign bus.stk_full  = w_full;
  assign bus.stk_empty = w_empty;
  assign bus.stk_err   = r_stk_err;
endmodule
